// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter that shares one I2C byte engine between two write requesters
// and sequences each granted transaction into START+address, data bytes and STOP.
module i2c_txn_arbiter #(
  parameter int unsigned        LEN_W   = 8,
  parameter int unsigned        TO_W    = 12,
  parameter logic [TO_W-1:0]    TIMEOUT = 12'd2000
) (
  input  logic             ck,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [6:0]       rq0_addr,
  input  logic [6:0]       rq1_addr,
  input  logic [LEN_W-1:0] rq0_len,
  input  logic [LEN_W-1:0] rq1_len,
  input  logic [7:0]       rq0_data,
  input  logic [7:0]       rq1_data,
  output logic [1:0]       gnt,
  output logic [1:0]       rq_take,
  output logic [1:0]       done,
  output logic [1:0]       err,
  output logic             eng_go,
  output logic             eng_start,
  output logic             eng_stop,
  output logic [7:0]       eng_byte,
  input  logic             eng_busy,
  input  logic             eng_done,
  input  logic             eng_ack
);

  typedef enum logic [2:0] {
    IDLE, GRANT, ADDR, ADDR_W, DATA, DATA_W, STOP, STOP_W
  } state_t;

  state_t           state, state_n;
  logic             win, win_n;
  logic             last, last_n;
  logic             err_f, err_f_n;
  logic             sel;
  logic [6:0]       addr_r, addr_n;
  logic [LEN_W-1:0] cnt, cnt_n;
  logic [TO_W-1:0]  wd, wd_n;
  logic [1:0]       gnt_n, take_n, done_n, err_n;
  logic             go_n, start_n, stop_n;
  logic [7:0]       byte_n;
  logic             wd_hit;

  assign wd_hit = (wd == TIMEOUT - 1'b1);

  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      win       <= 1'b0;
      last      <= 1'b1;
      err_f     <= 1'b0;
      addr_r    <= '0;
      cnt       <= '0;
      wd        <= '0;
      gnt       <= '0;
      rq_take   <= '0;
      done      <= '0;
      err       <= '0;
      eng_go    <= 1'b0;
      eng_start <= 1'b0;
      eng_stop  <= 1'b0;
      eng_byte  <= '0;
    end else begin
      state     <= state_n;
      win       <= win_n;
      last      <= last_n;
      err_f     <= err_f_n;
      addr_r    <= addr_n;
      cnt       <= cnt_n;
      wd        <= wd_n;
      gnt       <= gnt_n;
      rq_take   <= take_n;
      done      <= done_n;
      err       <= err_n;
      eng_go    <= go_n;
      eng_start <= start_n;
      eng_stop  <= stop_n;
      eng_byte  <= byte_n;
    end
  end

  // All outputs are registered: the comb block computes their next values.
  always_comb begin
    state_n = state;
    win_n   = win;
    last_n  = last;
    err_f_n = err_f;
    addr_n  = addr_r;
    cnt_n   = cnt;
    wd_n    = wd;
    gnt_n   = gnt;
    take_n  = '0;
    done_n  = '0;
    err_n   = '0;
    go_n    = 1'b0;
    start_n = eng_start;
    stop_n  = eng_stop;
    byte_n  = eng_byte;
    sel     = (req == 2'b11) ? ~last : req[1];

    case (state)
      IDLE: begin
        // done still high means the finishing requester has not yet had a cycle to drop req
        if (req != 2'b00 && done == 2'b00) begin
          win_n   = sel;
          addr_n  = sel ? rq1_addr : rq0_addr;
          cnt_n   = sel ? rq1_len : rq0_len;
          gnt_n   = sel ? 2'b10 : 2'b01;
          state_n = GRANT;
        end
      end
      GRANT: state_n = ADDR;
      ADDR: begin
        if (!eng_busy) begin
          go_n    = 1'b1;
          start_n = 1'b1;
          stop_n  = 1'b0;
          byte_n  = {addr_r, 1'b0};
          wd_n    = '0;
          state_n = ADDR_W;
        end
      end
      DATA: begin
        if (!eng_busy) begin
          go_n        = 1'b1;
          start_n     = 1'b0;
          stop_n      = 1'b0;
          byte_n      = win ? rq1_data : rq0_data;
          take_n[win] = 1'b1;
          cnt_n       = cnt - 1'b1;
          wd_n        = '0;
          state_n     = DATA_W;
        end
      end
      STOP: begin
        if (!eng_busy) begin
          go_n    = 1'b1;
          start_n = 1'b0;
          stop_n  = 1'b1;
          byte_n  = '0;
          wd_n    = '0;
          state_n = STOP_W;
        end
      end
      ADDR_W, DATA_W: begin
        if (eng_done) begin
          start_n = 1'b0;
          stop_n  = 1'b0;
          byte_n  = '0;
          if (eng_ack) begin
            err_f_n = 1'b1;
            state_n = STOP;
          end else if (cnt == '0) begin
            state_n = STOP;
          end else begin
            state_n = DATA;
          end
        end else if (wd_hit) begin
          start_n = 1'b0;
          stop_n  = 1'b0;
          byte_n  = '0;
          err_f_n = 1'b1;
          state_n = STOP;
        end else begin
          wd_n = wd + 1'b1;
        end
      end
      STOP_W: begin
        if (eng_done || wd_hit) begin
          done_n[win] = 1'b1;
          err_n[win]  = err_f | ~eng_done;
          gnt_n       = '0;
          last_n      = win;
          err_f_n     = 1'b0;
          start_n     = 1'b0;
          stop_n      = 1'b0;
          byte_n      = '0;
          state_n     = IDLE;
        end else begin
          wd_n = wd + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: doc/i2c_txn_arbiter.md
Name: i2c_txn_arbiter

Overview:
- Shares the single I2C byte engine between two requesters (index 0 = command sequencer, index 1 = LCD data streamer).
- Arbitrates round-robin at transaction granularity.
- Sequences each granted write transaction into engine operations: START plus address byte, N data bytes, then STOP.
- Reports completion and NACK/timeout errors per requester.

Parameters:
LEN_W, 8, width of per-requester byte-count field
TO_W, 12, width of watchdog counter
TIMEOUT, 12'd2000, ck cycles allowed from eng_go to eng_done before abort

Ports:
ck  in  1  system clock
reset  in  1  asynchronous, active-low reset
req  in  2  transaction request per requester, level, held until done
rq0_addr  in  7  requester 0 slave address
rq1_addr  in  7  requester 1 slave address
rq0_len  in  LEN_W  requester 0 data byte count (0 allowed)
rq1_len  in  LEN_W  requester 1 data byte count
rq0_data  in  8  requester 0 current data byte
rq1_data  in  8  requester 1 current data byte
gnt  out  2  one-hot grant, held for whole transaction
rq_take  out  2  1-cycle pulse: current data byte consumed, present next byte
done  out  2  1-cycle pulse: transaction finished
err  out  2  1-cycle pulse coincident with done: NACK or timeout
eng_go  out  1  1-cycle pulse: start one engine operation
eng_start  out  1  operation prefixed by START condition
eng_stop  out  1  operation is STOP only (no byte)
eng_byte  out  8  byte to send
eng_busy  in  1  engine busy
eng_done  in  1  1-cycle pulse: operation complete
eng_ack  in  1  sampled with eng_done; 0 = ACK, 1 = NACK

Behaviour:
- Reset (reset=0, async): state IDLE. gnt, rq_take, done, err, eng_go, eng_start, eng_stop all 0. eng_byte 8'h00. last-served pointer = 1, so requester 0 wins the first tie.
- States: IDLE, GRANT, ADDR, ADDR_W, DATA, DATA_W, STOP, STOP_W.
- IDLE: when req≠0, pick winner.
  - Only one requesting: that one wins.
  - Both requesting: the one not last served wins.
  - Latch winner's addr and len into internal registers; go to GRANT.
- GRANT: gnt[winner] rises (registered, 1 cycle after req is seen). Go to ADDR.
- ADDR: wait for eng_busy=0, then:
  - pulse eng_go with eng_start=1, eng_byte={addr,1'b0} (write only);
  - go to ADDR_W.
- DATA: wait for eng_busy=0, then:
  - pulse eng_go with eng_byte=rqN_data and eng_start=0;
  - pulse rq_take[winner] in the same cycle;
  - decrement byte counter;
  - go to DATA_W.
- STOP: wait for eng_busy=0, then pulse eng_go with eng_stop=1; go to STOP_W.
- ADDR_W / DATA_W, on eng_done:
  - eng_ack=1 → set error flag, go to STOP.
  - Else if counter=0 → STOP.
  - Else → DATA.
- STOP_W, on eng_done:
  - pulse done[winner], plus err[winner] if error flag set;
  - drop gnt in the same cycle;
  - update last-served pointer; clear error flag;
  - return to IDLE.
- New arbitration earliest 1 cycle after done. Back-to-back requests from both sides therefore alternate.
- eng_start, eng_stop and eng_byte hold stable from eng_go until the matching eng_done. Outside transactions they are 0.
- Watchdog: counter clears on eng_go and increments in each *_W state.
  - Reaching TIMEOUT in ADDR_W or DATA_W: set error flag, go to STOP.
  - Reaching TIMEOUT in STOP_W: force done+err, go to IDLE.
- len=0: address byte only, then STOP. No rq_take pulses.
- Requester dropping req mid-transaction is ignored; the transaction completes. req changes during grant do not re-arbitrate.
- A new len/addr on the granted requester is not sampled after IDLE.
- eng_done outside *_W states is ignored.
- Byte counter is LEN_W bits, loaded from len. Maximum len = 2^LEN_W−1; no wrap occurs.

Test Plan:
- req=01, rq0_addr=7'h27, rq0_len=2, data 8'h38 then 8'h0C, engine always ACKs.
  → eng_byte sequence 8'h4E(start), 8'h38, 8'h0C, stop.
  → two rq_take[0] pulses; done[0]=1, err=0; gnt[0] spans the whole transaction.
- req=11 simultaneously out of reset, both len=1.
  → requester 0 served first, then requester 1 without an intervening idle grant.
  → each sees exactly one done; gnt never 11.
- Requester 0, len=3, engine returns eng_ack=1 on 2nd data byte.
  → STOP issued next; done[0] and err[0] pulse together; only 2 rq_take pulses.
- Requester 1, len=0.
  → address 8'h4E with start, then stop; zero rq_take; done[1] without err.
- Engine never returns eng_done after a data eng_go.
  → after 2000 cycles STOP issued, err pulses.
  → reset asserted mid-STOP_W returns all outputs to zero immediately; after release, req=10 is granted normally.
